counter_multimode: RTL and testbench

Parametrised multi-mode counter that folds the team's separate up, down, up/down, mod-N, Gray, ring and Johnson counters into one block. The active mode is selected at run time. Every mode supports count direction, synchronous parallel load, a registered wrap pulse and a sticky overflow flag. It is the standard counter primitive for timers, sequencers and pointer generators.

---
 rtl/counter_multimode.sv | 144 ++++++++++++++
 tb/tb_counter_multimode.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_multimode.sv
// Multi-mode counter: binary, mod-N, Gray, ring and Johnson selectable at run time,
// with direction control, synchronous parallel load, a registered wrap pulse and a sticky overflow flag.
// Ports: clk/rst (async active-high), en/up/mode/mod_val/sat/load/load_val/clr_ovf in; count/wrap/ovf out.
// All outputs are registered, so there is no combinational path from any input to any output.
module counter_multimode #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [2:0] M_BIN  = 3'd0;
  localparam logic [2:0] M_MODN = 3'd1;
  localparam logic [2:0] M_GRAY = 3'd2;
  localparam logic [2:0] M_RING = 3'd3;
  localparam logic [2:0] M_JOHN = 3'd4;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1 = '1;

  // mode_q keeps the raw select so that a change between two BIN aliases (5-7) still reseeds.
  logic [2:0]       mode_q, mode_nxt;
  logic [2:0]       eff_q, eff_nxt;
  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [WIDTH-1:0] sh_q, sh_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] nm1;
  logic             wrap_nxt;
  logic             sat_hit;
  logic             sat_on;
  logic             ovf_nxt;

  assign eff_q   = (mode_q > M_JOHN) ? M_BIN : mode_q;
  assign eff_nxt = (mode_nxt > M_JOHN) ? M_BIN : mode_nxt;
  assign nm1     = mod_val - ONE;
  assign sat_on  = sat && (eff_q == M_BIN);  // GRAY shares the binary stepping but never saturates

  always_comb begin
    mode_nxt = mode_q;
    bin_nxt  = bin_q;
    sh_nxt   = sh_q;
    wrap_nxt = 1'b0;
    sat_hit  = 1'b0;
    if (mode != mode_q) begin
      mode_nxt = mode;
      bin_nxt  = ZERO;
      sh_nxt   = (mode == M_RING) ? ONE : ZERO;
    end else if (load) begin
      if (eff_q == M_RING || eff_q == M_JOHN) sh_nxt = load_val;
      else                                    bin_nxt = load_val;
    end else if (en) begin
      case (eff_q)
        M_MODN: begin
          if (mod_val <= ONE) begin
            bin_nxt  = ZERO;
            wrap_nxt = 1'b1;
          end else if (up) begin
            if (bin_q >= nm1) begin
              bin_nxt  = ZERO;
              wrap_nxt = 1'b1;
            end else begin
              bin_nxt = bin_q + ONE;
            end
          end else if (bin_q == ZERO) begin
            bin_nxt  = nm1;
            wrap_nxt = 1'b1;
          end else if (bin_q >= mod_val) begin
            // Out-of-range value (e.g. after a load) snaps to the top without a wrap.
            bin_nxt = nm1;
          end else begin
            bin_nxt = bin_q - ONE;
          end
        end
        M_RING: begin
          if (sh_q == ZERO) begin
            sh_nxt = ONE;
          end else begin
            sh_nxt   = up ? {sh_q[WIDTH-2:0], sh_q[WIDTH-1]} : {sh_q[0], sh_q[WIDTH-1:1]};
            wrap_nxt = (sh_nxt == ONE);
          end
        end
        M_JOHN: begin
          sh_nxt   = up ? {sh_q[WIDTH-2:0], ~sh_q[WIDTH-1]} : {~sh_q[0], sh_q[WIDTH-1:1]};
          wrap_nxt = (sh_nxt == ZERO);
        end
        default: begin  // BIN and GRAY
          if (up ? (bin_q == ALL1) : (bin_q == ZERO)) begin
            if (sat_on) begin
              sat_hit = 1'b1;
            end else begin
              bin_nxt  = up ? ZERO : ALL1;
              wrap_nxt = 1'b1;
            end
          end else begin
            bin_nxt = up ? bin_q + ONE : bin_q - ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    count_nxt = bin_nxt;
    case (eff_nxt)
      M_GRAY:         count_nxt = bin_nxt ^ (bin_nxt >> 1);
      M_RING, M_JOHN: count_nxt = sh_nxt;
      default:        count_nxt = bin_nxt;
    endcase
  end

  // A new overflow event in the same cycle takes precedence over clr_ovf.
  assign ovf_nxt = wrap_nxt | sat_hit | (ovf & ~clr_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= M_BIN;
      bin_q  <= ZERO;
      sh_q   <= ZERO;
      count  <= ZERO;
      wrap   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      bin_q  <= bin_nxt;
      sh_q   <= sh_nxt;
      count  <= count_nxt;
      wrap   <= wrap_nxt;
      ovf    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_multimode.sv
module tb_counter_multimode;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] mod_val = 8'd10, load_val = 8'd0;
  logic [7:0] count;
  logic       wrap, ovf;

  int checks = 0;
  int failures = 0;

  // Reference model state, plain integers
  int m_mode = 0, m_bin = 0, m_sh = 0, m_wrap = 0, m_ovf = 0;

  counter_multimode #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .mod_val(mod_val),
    .sat(sat), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count), .wrap(wrap), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int exp_count();
    int e;
    e = (m_mode > 4) ? 0 : m_mode;
    if (e == 2) return m_bin ^ (m_bin / 2);
    if (e >= 3) return m_sh;
    return m_bin;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, int'(count), exp_count());
    check({tag, ".wrap"}, int'(wrap), m_wrap);
    check({tag, ".ovf"}, int'(ovf), m_ovf);
  endtask

  // Apply the counter rules to the model using the inputs about to be sampled.
  task automatic model_step();
    int e, n, setov;
    m_wrap = 0;
    setov  = 0;
    e = (m_mode > 4) ? 0 : m_mode;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_bin  = 0;
      m_sh   = (mode == 3'd3) ? 1 : 0;
    end else if (load) begin
      if (e == 3 || e == 4) m_sh = int'(load_val);
      else                  m_bin = int'(load_val);
    end else if (en) begin
      case (e)
        1: begin
          n = int'(mod_val);
          if (n < 2) begin m_bin = 0; m_wrap = 1; end
          else if (up) begin
            if (m_bin >= n - 1) begin m_bin = 0; m_wrap = 1; end
            else m_bin = m_bin + 1;
          end else if (m_bin == 0) begin m_bin = n - 1; m_wrap = 1; end
          else if (m_bin >= n) m_bin = n - 1;
          else m_bin = m_bin - 1;
        end
        3: begin
          if (m_sh == 0) m_sh = 1;
          else begin
            if (up) m_sh = (m_sh * 2) % 256 + m_sh / 128;
            else    m_sh = m_sh / 2 + (m_sh % 2) * 128;
            m_wrap = (m_sh == 1);
          end
        end
        4: begin
          if (up) m_sh = (m_sh * 2) % 256 + ((m_sh < 128) ? 1 : 0);
          else    m_sh = m_sh / 2 + ((m_sh % 2 == 0) ? 128 : 0);
          m_wrap = (m_sh == 0);
        end
        default: begin
          if ((up && m_bin == 255) || (!up && m_bin == 0)) begin
            if (e == 0 && sat) setov = 1;
            else begin m_bin = up ? 0 : 255; m_wrap = 1; end
          end else m_bin = up ? m_bin + 1 : m_bin - 1;
        end
      endcase
    end
    m_ovf = (clr_ovf ? 0 : m_ovf) | m_wrap | setov;
  endtask

  // One clock: update model, take the edge, check away from the edge.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  int prev;
  int hd;

  initial begin
    // Reset state
    #3;
    check_outputs("reset");
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // BIN up, wrapping: 256 steps
    mode = 3'd0; en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 256; i++) cyc("bin_up");
    check("bin_wrap_to_0", int'(count), 0);
    check("bin_wrap_pulse", int'(wrap), 1);
    en = 1'b0; clr_ovf = 1'b1; cyc("bin_clr");
    clr_ovf = 1'b0; en = 1'b1; sat = 1'b1;
    for (int i = 0; i < 257; i++) cyc("bin_sat");
    check("bin_sat_hold", int'(count), 255);
    check("bin_sat_ovf", int'(ovf), 1);
    sat = 1'b0;

    // MODN, mod 10
    mode = 3'd1; mod_val = 8'd10; en = 1'b1; up = 1'b1;
    cyc("modn_enter");
    for (int i = 0; i < 24; i++) cyc("modn_up");
    check("modn_at_4", int'(count), 4);
    up = 1'b0;
    for (int i = 0; i < 5; i++) cyc("modn_dn");
    check("modn_dn_9", int'(count), 9);
    check("modn_dn_wrap", int'(wrap), 1);
    mod_val = 8'd1;
    for (int i = 0; i < 4; i++) cyc("modn_n1");
    load = 1'b1; load_val = 8'd200; mod_val = 8'd10; cyc("modn_load_oor");
    load = 1'b0; cyc("modn_dn_oor");

    // GRAY up 16 steps, each step a single bit change
    mode = 3'd2; up = 1'b1;
    cyc("gray_enter");
    prev = int'(count);
    for (int i = 0; i < 16; i++) begin
      cyc("gray_up");
      hd = $countones(prev ^ int'(count));
      check("gray_hamming", hd, 1);
      prev = int'(count);
    end
    check("gray_16th", int'(count), 8'h18);
    load = 1'b1; load_val = 8'd0; cyc("gray_load0");
    load = 1'b0; up = 1'b0; cyc("gray_dn");
    check("gray_dn_80", int'(count), 8'h80);

    // BIN -> RING with a load in the switch cycle that must be ignored
    mode = 3'd0; load = 1'b1; load_val = 8'd37; cyc("bin_reenter");
    cyc("bin_load37");
    mode = 3'd3; load_val = 8'hA5; cyc("ring_enter");
    check("ring_seed", int'(count), 1);
    load = 1'b0; up = 1'b1;
    for (int i = 0; i < 8; i++) cyc("ring_up");
    check("ring_wrap", int'(wrap), 1);
    load = 1'b1; load_val = 8'h00; cyc("ring_load0");
    load = 1'b0; cyc("ring_fix");
    check("ring_fix_val", int'(count), 1);
    up = 1'b0;
    for (int i = 0; i < 9; i++) cyc("ring_dn");

    // JOHNSON
    mode = 3'd4; up = 1'b1; cyc("john_enter");
    for (int i = 0; i < 16; i++) cyc("john_up");
    check("john_period", int'(count), 0);
    up = 1'b0;
    for (int i = 0; i < 16; i++) cyc("john_dn");

    // Priorities: load with en=0, wrap beats clr_ovf
    mode = 3'd0; en = 1'b0; cyc("prio_bin");
    load = 1'b1; load_val = 8'h5A; cyc("prio_load");
    check("prio_load_val", int'(count), 8'h5A);
    load_val = 8'hFF; cyc("prio_load_ff");
    load = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1; cyc("prio_wrap_clr");
    check("prio_ovf_wins", int'(ovf), 1);
    clr_ovf = 1'b0;

    // Asynchronous reset mid-count
    for (int i = 0; i < 5; i++) cyc("pre_rst");
    #1 rst = 1'b1;
    #1;
    m_mode = 0; m_bin = 0; m_sh = 0; m_wrap = 0; m_ovf = 0;
    check_outputs("async_rst");
    #1 rst = 1'b0;
    mode = 3'd3; cyc("rst_reseed_ring");

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) mode = 3'($urandom_range(7));
      en       = ($urandom_range(3) != 0);
      up       = 1'($urandom);
      sat      = 1'($urandom);
      load     = ($urandom_range(9) == 0);
      load_val = 8'($urandom);
      mod_val  = ($urandom_range(3) == 0) ? 8'($urandom_range(2)) : 8'($urandom_range(20));
      clr_ovf  = ($urandom_range(7) == 0);
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
